// File: rtl/triangle_wave_monitor_if.sv
// Bus between the triangle waveform source and its receive-side monitor:
// the sampled wave plus the status flags and counters reported back.
interface triangle_wave_monitor_if #(
    parameter int WIDTH = 5,
    parameter int PER_W = 8,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] wave;
    logic             dir;
    logic             peak;
    logic             trough;
    logic             err;
    logic             locked;
    logic [PER_W-1:0] period_len;
    logic             period_vld;
    logic [ERR_W-1:0] err_count;

    modport master (
        output wave,
        input  dir, peak, trough, err, locked, period_len, period_vld, err_count
    );

    modport slave (
        input  wave,
        output dir, peak, trough, err, locked, period_len, period_vld, err_count
    );
endinterface

// File: rtl/triangle_wave_monitor.sv
// Receive-side checker for the triangle waveform bus: tracks ramp direction,
// flags peaks/troughs, measures trough-to-trough period and counts illegal steps.
module triangle_wave_monitor #(
    parameter int WIDTH        = 5,
    parameter int PER_W        = 8,
    parameter int ERR_W        = 8,
    parameter int LOCK_TROUGHS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    triangle_wave_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        UP,
        DOWN
    } state_e;

    localparam int               GOOD_W   = $clog2(LOCK_TROUGHS + 1);
    localparam logic [WIDTH-1:0] WAVE_MAX = '1;
    localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);
    localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_TROUGHS);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [PER_W-1:0]   pctr_q, pctr_d;
    logic               seen_trough_q, seen_trough_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic               dir_q, dir_d;
    logic               peak_q, peak_d;
    logic               trough_q, trough_d;
    logic               err_q, err_d;
    logic               locked_q, locked_d;
    logic [PER_W-1:0]   period_len_q, period_len_d;
    logic               period_vld_q, period_vld_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;

    // One extra bit keeps 31+1 from aliasing onto 0 and 0-1 onto 31.
    logic [WIDTH:0] wave_x;
    logic [WIDTH:0] prev_x;
    logic           step_up;
    logic           step_dn;
    logic           at_max;
    logic           at_zero;

    assign wave_x  = {1'b0, mon.wave};
    assign prev_x  = {1'b0, prev_q};
    assign step_up = (wave_x == prev_x + ONE_X);
    assign step_dn = (wave_x == prev_x - ONE_X);
    assign at_max  = (mon.wave == WAVE_MAX);
    assign at_zero = (mon.wave == '0);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        prev_d        = mon.wave;
        pctr_d        = pctr_q;
        seen_trough_d = seen_trough_q;
        good_d        = good_q;
        peak_d        = 1'b0;
        trough_d      = 1'b0;
        err_d         = 1'b0;
        period_len_d  = period_len_q;
        period_vld_d  = period_vld_q;
        err_count_d   = err_count_q;

        unique case (state_q)
            IDLE: begin
                state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (step_up) begin
                    state_d = at_max ? DOWN : UP;
                    peak_d  = at_max;
                end else if (step_dn) begin
                    state_d  = at_zero ? UP : DOWN;
                    trough_d = at_zero;
                end else begin
                    err_d = 1'b1;
                end
            end
            UP: begin
                if (step_up) begin
                    state_d = at_max ? DOWN : UP;
                    peak_d  = at_max;
                end else begin
                    state_d = ACQUIRE;
                    err_d   = 1'b1;
                end
            end
            DOWN: begin
                if (step_dn) begin
                    state_d  = at_zero ? UP : DOWN;
                    trough_d = at_zero;
                end else begin
                    state_d = ACQUIRE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An error restarts both the period measurement and the lock count.
        if (err_d) begin
            pctr_d        = '0;
            seen_trough_d = 1'b0;
            good_d        = '0;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + ERR_W'(1);
            end
        end else if (trough_d) begin
            if (seen_trough_q) begin
                period_len_d = (pctr_q == '1) ? pctr_q : pctr_q + PER_W'(1);
                period_vld_d = 1'b1;
            end
            pctr_d        = '0;
            seen_trough_d = 1'b1;
            if (good_q != GOOD_FULL) begin
                good_d = good_q + GOOD_W'(1);
            end
        end else if (state_q != IDLE && pctr_q != '1) begin
            pctr_d = pctr_q + PER_W'(1);
        end

        dir_d    = (state_d == UP);
        locked_d = (good_d == GOOD_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            prev_q        <= '0;
            pctr_q        <= '0;
            seen_trough_q <= 1'b0;
            good_q        <= '0;
            dir_q         <= 1'b0;
            peak_q        <= 1'b0;
            trough_q      <= 1'b0;
            err_q         <= 1'b0;
            locked_q      <= 1'b0;
            period_len_q  <= '0;
            period_vld_q  <= 1'b0;
            err_count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            prev_q        <= prev_d;
            pctr_q        <= pctr_d;
            seen_trough_q <= seen_trough_d;
            good_q        <= good_d;
            dir_q         <= dir_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            err_q         <= err_d;
            locked_q      <= locked_d;
            period_len_q  <= period_len_d;
            period_vld_q  <= period_vld_d;
            err_count_q   <= err_count_d;
        end
    end

    assign mon.dir        = dir_q;
    assign mon.peak       = peak_q;
    assign mon.trough     = trough_q;
    assign mon.err        = err_q;
    assign mon.locked     = locked_q;
    assign mon.period_len = period_len_q;
    assign mon.period_vld = period_vld_q;
    assign mon.err_count  = err_count_q;

endmodule

// File: tb/tb_triangle_wave_monitor.sv
// Scoreboard bench for triangle_wave_monitor: a step-level reference model pushes
// expected outputs per sample; a monitor pops and compares after every edge.
module tb_triangle_wave_monitor;

    localparam int MAXV = 31;
    localparam int PMAX = 255;
    localparam int EMAX = 255;
    localparam int LOCK = 2;

    typedef struct {
        int dir;
        int peak;
        int trough;
        int err;
        int locked;
        int period_len;
        int period_vld;
        int err_count;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    triangle_wave_monitor_if #(.WIDTH(5), .PER_W(8), .ERR_W(8)) bus ();

    triangle_wave_monitor #(
        .WIDTH(5), .PER_W(8), .ERR_W(8), .LOCK_TROUGHS(LOCK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the last sample and what kind of ramp is expected,
    // judging each step by plain integer difference.
    int  m_mode;       // 0 fresh after reset, 1 searching, 2 rising, 3 falling
    int  m_prev;
    int  m_edges;
    bit  m_seen;
    int  m_good;
    int  m_plen;
    bit  m_pvld;
    int  m_errs;

    task automatic model_reset();
        m_mode  = 0;
        m_prev  = 0;
        m_edges = 0;
        m_seen  = 0;
        m_good  = 0;
        m_plen  = 0;
        m_pvld  = 0;
        m_errs  = 0;
    endtask

    task automatic model_step(input int w);
        exp_t e;
        int   delta;
        bit   pk, tr, bad;
        pk = 0; tr = 0; bad = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            delta = w - m_prev;
            if (delta == 1 && m_mode != 3) begin
                pk     = (w == MAXV);
                m_mode = pk ? 3 : 2;
            end else if (delta == -1 && m_mode != 2) begin
                tr     = (w == 0);
                m_mode = tr ? 2 : 3;
            end else begin
                bad    = 1;
                m_mode = 1;
            end
            if (bad) begin
                m_edges = 0;
                m_seen  = 0;
                m_good  = 0;
                m_errs  = (m_errs < EMAX) ? m_errs + 1 : EMAX;
            end else if (tr) begin
                if (m_seen) begin
                    m_plen = (m_edges + 1 > PMAX) ? PMAX : m_edges + 1;
                    m_pvld = 1;
                end
                m_edges = 0;
                m_seen  = 1;
                m_good  = (m_good < LOCK) ? m_good + 1 : LOCK;
            end else begin
                m_edges = (m_edges < PMAX) ? m_edges + 1 : PMAX;
            end
        end
        m_prev       = w;
        e.dir        = (m_mode == 2);
        e.peak       = pk;
        e.trough     = tr;
        e.err        = bad;
        e.locked     = (m_good == LOCK);
        e.period_len = m_plen;
        e.period_vld = m_pvld;
        e.err_count  = m_errs;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dir",        32'(bus.dir),        32'(e.dir));
            check("peak",       32'(bus.peak),       32'(e.peak));
            check("trough",     32'(bus.trough),     32'(e.trough));
            check("err",        32'(bus.err),        32'(e.err));
            check("locked",     32'(bus.locked),     32'(e.locked));
            check("period_len", 32'(bus.period_len), 32'(e.period_len));
            check("period_vld", 32'(bus.period_vld), 32'(e.period_vld));
            check("err_count",  32'(bus.err_count),  32'(e.err_count));
        end
    end

    // Called at a falling edge; returns at the next falling edge with the sample consumed.
    task automatic drive(input int w);
        rst      = 1'b0;
        bus.wave = 5'(w);
        model_step(w);
        @(negedge clk);
    endtask

    task automatic ramp(input int a, input int b);
        if (a <= b) for (int v = a; v <= b; v++) drive(v);
        else        for (int v = a; v >= b; v--) drive(v);
    endtask

    task automatic tri_run(input int n);
        for (int i = 0; i < n; i++) begin
            int p;
            p = i % 62;
            drive(p <= MAXV ? p : 62 - p);
        end
    endtask

    // Called at a falling edge; reset is left asserted until the next drive().
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_dir",        32'(bus.dir),        0);
        check("rst_peak",       32'(bus.peak),       0);
        check("rst_trough",     32'(bus.trough),     0);
        check("rst_err",        32'(bus.err),        0);
        check("rst_locked",     32'(bus.locked),     0);
        check("rst_period_len", 32'(bus.period_len), 0);
        check("rst_period_vld", 32'(bus.period_vld), 0);
        check("rst_err_count",  32'(bus.err_count),  0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        bus.wave = '0;
        model_reset();
        @(negedge clk);

        // Clean triangle
        do_reset();
        tri_run(200);
        check("clean_period_len", 32'(bus.period_len), 62);
        check("clean_period_vld", 32'(bus.period_vld), 1);
        check("clean_locked",     32'(bus.locked),     1);
        check("clean_err_count",  32'(bus.err_count),  0);

        // Illegal jump while locked, then relock
        do_reset();
        tri_run(195);
        ramp(9, 11);
        check("jump_pre_locked", 32'(bus.locked), 1);
        drive(14);
        check("jump_err",        32'(bus.err),        1);
        check("jump_locked",     32'(bus.locked),     0);
        check("jump_err_count",  32'(bus.err_count),  1);
        check("jump_period_vld", 32'(bus.period_vld), 1);
        drive(15);
        check("jump_resume_dir", 32'(bus.dir), 1);
        ramp(16, 31);
        ramp(30, 0);
        check("relock_one_trough", 32'(bus.locked), 0);
        ramp(1, 31);
        ramp(30, 0);
        check("relock_two_troughs", 32'(bus.locked), 1);
        check("relock_period_len",  32'(bus.period_len), 62);

        // Reset while locked, then start mid-ramp
        do_reset();
        ramp(20, 18);
        check("midramp_dir", 32'(bus.dir), 0);
        check("midramp_err", 32'(bus.err), 0);
        ramp(17, 0);
        check("midramp_trough",     32'(bus.trough),     1);
        check("midramp_period_vld", 32'(bus.period_vld), 0);

        // Repeated sample while falling
        ramp(1, 31);
        ramp(30, 5);
        drive(5);
        check("repeat_err", 32'(bus.err), 1);
        drive(4);
        drive(3);
        check("repeat_dir",       32'(bus.dir),       0);
        check("repeat_no_err",    32'(bus.err),       0);
        check("repeat_err_count", 32'(bus.err_count), 1);

        // Wrap attempts
        ramp(2, 0);
        ramp(1, 31);
        drive(0);
        check("wrap_hi_err",       32'(bus.err),       1);
        check("wrap_hi_err_count", 32'(bus.err_count), 2);
        drive(31);
        check("wrap_lo_err",       32'(bus.err),       1);
        check("wrap_lo_err_count", 32'(bus.err_count), 3);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) drive(((i % 2) == 0) ? 3 : 7);
        check("sat_err_count", 32'(bus.err_count), 255);
        for (int i = 0; i < 4; i++) drive(((i % 2) == 0) ? 3 : 7);
        check("sat_err_count_hold", 32'(bus.err_count), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/triangle_wave_monitor.md
# triangle_wave_monitor

Receive-side checker for the 5-bit triangle waveform bus driven by the on-chip signal generator. Samples `wave` every clock, tracks ramp direction, flags peaks and troughs, measures the period and detects any step that is not a legal ±1 ramp or turn-around. Its outputs are status flags and counters that feed the test and debug status registers.

## Interface
- `WIDTH`, default 5: wave bus width; MAX = 2^WIDTH−1 (31).
- `PER_W`, default 8: width of the period counter and `period_len`.
- `ERR_W`, default 8: width of `err_count`.
- `LOCK_TROUGHS`, default 2: number of consecutive error-free troughs required to assert `locked`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wave` in WIDTH: waveform sample, sampled on every rising edge.
- `dir` out 1: 1 = ramping up (state UP), 0 = any other state.
- `peak` out 1: one-cycle pulse; a legal up-step reached MAX.
- `trough` out 1: one-cycle pulse; a legal down-step reached 0.
- `err` out 1: one-cycle pulse; an illegal step was detected.
- `locked` out 1: at least LOCK_TROUGHS troughs seen since the last error or reset.
- `period_len` out PER_W: last measured trough-to-trough distance, in clock edges.
- `period_vld` out 1: `period_len` holds a valid measurement.
- `err_count` out ERR_W: total errors since reset; saturates at all-ones.

## Operation
- States: IDLE, ACQUIRE, UP, DOWN.
- Register `prev` holds the previous sample. Compare `wave` against prev+1 and prev−1 in WIDTH+1 bits, so 31+1 never matches 0 and 0−1 never matches 31.
- IDLE: prev←wave; go to ACQUIRE. No pulses.
- ACQUIRE, UP and DOWN all update prev←wave on every edge.
- ACQUIRE:
  - wave==prev+1: go to UP, or to DOWN with `peak` if wave==MAX.
  - wave==prev−1: go to DOWN, or to UP with `trough` if wave==0.
  - Otherwise, including a repeated value: `err`, stay in ACQUIRE.
- UP:
  - wave==prev+1: stay in UP, or go to DOWN with `peak` if wave==MAX.
  - Otherwise: `err`, go to ACQUIRE.
- DOWN:
  - wave==prev−1: stay in DOWN, or go to UP with `trough` if wave==0.
  - Otherwise: `err`, go to ACQUIRE.
- Period measurement:
  - `pctr` counts edges in ACQUIRE, UP and DOWN; it saturates at all-ones.
  - Flag `seen_trough` is set by any trough.
  - On a trough with `seen_trough` already 1: period_len←pctr+1 (saturating), period_vld←1, pctr←0.
  - On the first trough after reset or an error: pctr←0 only.
  - On `err`: pctr←0 and seen_trough←0. `period_len` and `period_vld` keep their last values.
- Lock:
  - `good` counts troughs and saturates at LOCK_TROUGHS; `locked` = (good==LOCK_TROUGHS).
  - On `err`: good←0.
- `err_count` increments on each `err` and saturates.
- Reset value of every output, and of `pctr`, `good`, `seen_trough` and `prev`, is 0. State resets to IDLE.

## Timing
- All outputs are registered. A pulse caused by the sample taken at edge k is high from edge k to edge k+1 (one cycle), and so are the resulting `dir`, `locked`, `period_len` and `err_count` updates.
- `locked` drops on the same edge that raises `err`.
- `locked` rises on the same edge as the trough that completes the count.
- Peak and trough can never occur on the same edge. `err` excludes both.
- Latency to the first state decision after reset release is 2 edges: IDLE, then ACQUIRE evaluation.
- Asserting `rst` at any time clears everything immediately, including mid-ramp and mid-pulse. Tracking resumes from IDLE.
- Ideal waveform 0→31→0: `period_len` = 62. The period is bounded only by PER_W saturation.

## Test plan
- Clean triangle: rst 1→0, wave = 0,1,…,31,30,…,0,1,… for 200 edges.
  - `peak` is high for one cycle after each sample of 31; `trough` after each later 0.
  - After the second trough: period_len=62, period_vld=1.
  - `locked`=1 after the second trough; err_count=0.
- Illegal jump: locked stream at 10,11, then 14.
  - `err` pulses once; locked→0; err_count=1; period_vld stays 1.
  - Resume 15,16,…: returns to UP on the next legal step; locked only after two further troughs.
- Repeated sample: in DOWN, feed 5,5 → `err`. Then 4,3 → state DOWN, dir=0, no second error.
- Wrap attempts: 31 then 0 → `err`. 0 then 31 → `err`. Each increments err_count.
- Start mid-ramp: reset release with wave = 20,19,18 → DOWN, dir=0, no `err`. At 0: `trough` pulses with period_vld still 0.
- Reset mid-operation and saturation:
  - Assert rst while locked → all outputs read 0 in the same cycle.
  - Force 300 errors (wave alternating 3,7) → err_count=255, holding.
